multiword_add_seq: RTL and testbench

//  Sequencer that time-shares the single 16-bit adder datapath to perform WORDS*16-bit add/subtract.

---
 rtl/multiword_add_seq.sv | 105 ++++++++++
 tb/tb_multiword_add_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: runs a WORDS*16-bit add/subtract through one shared 16-bit adder, one slice per cycle
// Ports: clk/reset (async, active-high); in_valid/in_ready/in_a/in_b/in_sub request side;
// add_a/add_b/add_cin drive the external adder, add_r/add_cout come back from it;
// out_valid/out_ready/out_sum/out_cout/out_ovf result side; busy is high in RUN or DONE.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  input  logic                in_sub,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_r,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf,
  output logic                busy
);
  localparam int W  = 16 * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, sub_q, sub_d, ovf_q, ovf_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic last;
  logic [15:0] b_sl;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    last    = idx_q == IW'(WORDS - 1);
    b_sl    = b_q[idx_q*16 +: 16];
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = in_a;
        b_d     = in_b;
        sub_d   = in_sub;
        idx_d   = '0;
        carry_d = in_sub;
        state_d = RUN;
      end
      RUN: begin
        add_a   = a_q[idx_q*16 +: 16];
        add_b   = sub_q ? ~b_sl : b_sl;
        add_cin = carry_q;
        sum_d[idx_q*16 +: 16] = add_r;
        carry_d = add_cout;
        if (last) begin
          // signed overflow judged on the top slice only, where the sign bits live
          ovf_d   = (add_a[15] == add_b[15]) && (add_r[15] != add_a[15]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_sum   = sum_q;
  // the chained carry register already holds the final carry once RUN ends
  assign out_cout  = carry_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: vector table, corner sequences and random ops against a wide-arithmetic model
module tb_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int W = 16 * WORDS;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, add_cin, add_cout, out_valid, out_cout, out_ovf, busy;
  logic [15:0] add_a, add_b, add_r;
  logic [W-1:0] out_sum;
  int checks = 0, errors = 0;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_r(add_r), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  assign {add_cout, add_r} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b;
    logic sub;
    logic [W-1:0] sum;
    logic cout, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic v);
    logic [W:0] t;
    if (sub) begin
      s = a - b;
      c = a >= b;
      v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      t = {1'b0, a} + {1'b0, b};
      s = t[W-1:0];
      c = t[W];
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", W'(in_ready), W'(1));
  endtask

  // issue one request and wait for out_valid, checking latency; leaves DUT in DONE
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int n = 0;
    wait_ready();
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_sub = ~sub;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", W'(n), W'(WORDS));
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] s, input logic c, input logic v);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_cout"}, W'(out_cout), W'(c));
    chk({tag, "_ovf"}, W'(out_ovf), W'(v));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_accept", W'({in_ready, busy, out_valid}), W'(3'b100));
  endtask

  initial begin
    vec_t tbl[6];
    logic [W-1:0] s, a, b;
    logic c, v, sub;
    tbl[0] = '{64'h0000FFFFFFFFFFFF, 64'h1, 1'b0, 64'h0001000000000000, 1'b0, 1'b0};
    tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    tbl[2] = '{64'h0, 64'h1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    tbl[3] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0};
    tbl[4] = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 64'h8000000000000000, 1'b0, 1'b1};
    tbl[5] = '{64'h8000000000000000, 64'h1, 1'b1, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b1};

    #1;
    chk("rst_flags", W'({in_ready, out_valid, busy, out_cout, out_ovf}), W'(5'b10000));
    chk("rst_sum", out_sum, '0);
    chk("rst_add", W'({add_a, add_b, add_cin}), '0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      start_op(tbl[i].a, tbl[i].b, tbl[i].sub);
      check_result($sformatf("vec%0d", i), tbl[i].sum, tbl[i].cout, tbl[i].ovf);
      release_out();
    end

    // backpressure: result must sit still and new requests must be ignored
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0);
    model(64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0, s, c, v);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2);
      in_a = 64'hDEAD; in_b = 64'hBEEF;
      @(posedge clk); #1;
      chk("bp_hold_valid", W'({out_valid, in_ready, busy}), W'(3'b101));
      check_result("bp", s, c, v);
    end
    in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    chk("bp_no_spurious", W'({in_ready, busy}), W'(2'b10));

    // reset while RUN is at slice 2
    wait_ready();
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'h1; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_run_busy", W'(busy), W'(1));
    reset = 1'b1; #1;
    chk("abort_flags", W'({out_valid, busy, in_ready}), W'(3'b001));
    chk("abort_add", W'({add_a, add_b, add_cin}), '0);
    chk("abort_sum", out_sum, '0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    start_op(64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    check_result("after_rst", 64'h0000_0001_0001_0000, 1'b0, 1'b0);
    release_out();

    // random operands, with occasional all-ones/sign-boundary words to stress carries
    for (int i = 0; i < 150; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[47:0] = '1;
      if ($urandom_range(0, 3) == 0) b = {$urandom_range(0, 1) ? 16'h8000 : 16'h7FFF, 48'h0};
      sub = $urandom_range(0, 1);
      model(a, b, sub, s, c, v);
      start_op(a, b, sub);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      check_result($sformatf("rnd%0d", i), s, c, v);
      release_out();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
